// File: rtl/bitmap_loader_if.sv
// Pixel stream in / memory write bus out for bitmap_loader.
// master: the side that produces pixel bytes and consumes memory writes.
// slave:  the loader itself.
interface bitmap_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDS_WIDTH = 18
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/bitmap_loader.sv
// Bitmap loader: accepts a stream of pixel bytes and writes one frame of
// IMG_WIDTH x IMG_HEIGHT pixels to memory at addresses 0..W*H-1.
// Optional feature: define BITMAP_LOADER_SYNC_EN to insert a SYNC phase that
// discards bytes until 8'hA5 is seen before loading starts.
module bitmap_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDS_WIDTH = 18,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    bitmap_loader_if.slave  bus,
    output logic            busy,
    output logic            frame_done
);
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
`ifdef BITMAP_LOADER_SYNC_EN
    localparam logic [DATA_WIDTH-1:0] SYNC_WORD = DATA_WIDTH'(8'hA5);
`endif

    typedef enum logic [1:0] {IDLE, SYNC, LOAD, DONE} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic [ADDS_WIDTH-1:0] pix_q;
    logic                  wr_en_q;
    logic [ADDS_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  in_ready;
    logic                  accept;
    logic                  last_pix;

    // abort masks in_ready so the byte offered alongside abort is never taken
    assign accept   = in_ready & bus.in_valid;
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
`ifdef BITMAP_LOADER_SYNC_EN
                    state_d = SYNC;
`else
                    state_d = LOAD;
`endif
                end
            end
            SYNC: begin
`ifdef BITMAP_LOADER_SYNC_EN
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && (bus.in_data == SYNC_WORD)) begin
                    state_d = LOAD;
                end
`else
                state_d = IDLE;
`endif
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && last_pix) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            SYNC, LOAD: begin
                in_ready = !abort;
                busy     = 1'b1;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Pixel counters and registered write port; counters rearm while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            pix_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (state_q == IDLE) begin
                x_q   <= '0;
                y_q   <= '0;
                pix_q <= '0;
            end else if ((state_q == LOAD) && accept) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= pix_q;
                wr_data_q <= bus.in_data;
                pix_q     <= pix_q + ADDS_WIDTH'(1);
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end
endmodule
